pe_feeder: RTL and testbench
============================

// Module: pe_feeder
// PURPOSE
//  Transmit side of the PE operand interface: drives pe_input/pe_weight/pe_en of one PE row.
//  Accepts a pixel stream (valid/ready), buffers it in a small FIFO, pairs each pixel with
//  the kernel weight for its tap position, and emits one enabled operand pair per cycle.
//  Sits between the line buffer / pixel source and the first PE of a systolic row.
// PARAMETERS
//  DATA_WIDTH    8   pixel width
//  WEIGHT_WIDTH  8   weight width
//  KERNEL_LEN    9   taps per window (weights held in register file, addr 0..KERNEL_LEN-1)
//  FIFO_DEPTH    4   pixel buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1                      clock
//  rstn         in   1                      reset: synchronous, active-low
//  cfg_wr_en    in   1                      weight write strobe
//  cfg_wr_addr  in   $clog2(KERNEL_LEN)     weight index
//  cfg_wr_data  in   WEIGHT_WIDTH           weight value
//  num_windows  in   16                     windows per job, sampled on start
//  start        in   1                      job start pulse
//  pix_valid    in   1                      source pixel valid
//  pix_data     in   DATA_WIDTH             source pixel
//  pix_ready    out  1                      feeder accepts pixel (comb)
//  pe_input     out  DATA_WIDTH             operand pixel to PE (registered)
//  pe_weight    out  WEIGHT_WIDTH           operand weight to PE (registered)
//  pe_en        out  1                      operand valid to PE (registered)
//  win_last     out  1                      qualifies pe_en: last tap of current window
//  busy         out  1                      job in progress (state != IDLE)
//  done         out  1                      one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, tap/window/push/pop counters 0, weight regs 0, state IDLE.
//  FSM IDLE -> RUN on start (num_windows!=0); IDLE -> DONE on start with num_windows==0;
//   RUN -> DONE when pop_cnt reaches total = num_windows*KERNEL_LEN; DONE -> IDLE next cycle.
//  done=1 exactly while in DONE (1 cycle). start ignored outside IDLE.
//  Weights: cfg_wr_en writes w[cfg_wr_addr] only in IDLE; ignored when busy; addr>=KERNEL_LEN ignored.
//  pix_ready = (state==RUN) && !fifo_full && (push_cnt < total). Push on pix_valid&&pix_ready.
//   Never accepts beyond total; excess source pixels remain stalled.
//  Pop: in RUN with FIFO non-empty, every cycle: pe_en<=1, pe_input<=head,
//   pe_weight<=w[tap], win_last<=(tap==KERNEL_LEN-1); tap wraps KERNEL_LEN-1 -> 0.
//  No pop: pe_en<=0, pe_input<=0, pe_weight<=0, win_last<=0 (matches PE zeroing convention).
//  Latency: pixel accepted at edge k is on pe_input after edge k+1 (FIFO empty, no stall).
//  Push and pop in same cycle allowed at any occupancy <FULL; FULL blocks push (ready low).
//  FIFO pointers wrap modulo FIFO_DEPTH; count register width $clog2(FIFO_DEPTH)+1.
//  total width 16+$clog2(KERNEL_LEN) bits; no overflow possible.
//  Source bubbles: pe_en deasserts, tap holds; window resumes at next pixel (no tap skip).
//  Reset mid-job: all state cleared as above, FIFO contents dropped, weights cleared, no done.
//  done asserted cycle after final pe_en; final pe_en always has win_last=1.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/RUN/DONE), total-count width function.
//  Sub-module: pe_feeder_fifo (synchronous FIFO, DATA_WIDTH x FIFO_DEPTH, push/pop/full/empty/count).
//  Top holds FSM, counters, weight register file, output registers.
// TESTING
//  Weights 1..9, num_windows=1, pixels 10..18 back-to-back -> 9 pe_en cycles, pe_weight 1..9,
//   win_last only on pixel 18, done 1 cycle later, busy low after.
//  num_windows=2, pix_valid toggling 50% -> 18 pe_en, tap order 0..8,0..8, no tap skipped.
//  Source streams 20 pixels for num_windows=2 -> exactly 18 accepted, pix_ready low afterwards.
//  start with num_windows=0 -> done next cycle, no pe_en, pix_ready never high.
//  cfg_wr_en (addr 0, data 0x55) while busy -> w[0] unchanged for next job; in IDLE -> 0x55 used.
//  rstn low for 1 cycle after 5 pops -> all outputs 0, no done; new job restarts at tap 0.

Source files
------------

// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE operand feeder: FSM states and job-count sizing.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width that holds num_windows (16 bits) times KERNEL_LEN without overflow.
  function automatic int unsigned total_width(input int unsigned kernel_len);
    return 16 + $clog2(kernel_len);
  endfunction

endpackage

// File: rtl/pe_feeder_fifo.sv
// Synchronous pixel FIFO; head is the oldest entry, valid whenever empty is low.
module pe_feeder_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// PE row operand feeder: buffers a pixel stream and pairs each pixel with its tap weight.
module pe_feeder
  import pe_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned KERNEL_LEN   = 9,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(KERNEL_LEN)-1:0] cfg_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]       cfg_wr_data,
  input  logic [15:0]                   num_windows,
  input  logic                          start,
  input  logic                          pix_valid,
  input  logic [DATA_WIDTH-1:0]         pix_data,
  output logic                          pix_ready,
  output logic [DATA_WIDTH-1:0]         pe_input,
  output logic [WEIGHT_WIDTH-1:0]       pe_weight,
  output logic                          pe_en,
  output logic                          win_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned AW = $clog2(KERNEL_LEN);
  localparam int unsigned TW = total_width(KERNEL_LEN);
  localparam logic [AW-1:0] TAP_LAST = AW'(KERNEL_LEN - 1);
  localparam logic [AW:0]   KLEN_A   = (AW + 1)'(KERNEL_LEN);
  localparam logic [TW-1:0] KLEN_T   = TW'(KERNEL_LEN);

  state_t                  state;
  state_t                  state_nx;
  logic [TW-1:0]           total;
  logic [TW-1:0]           push_cnt;
  logic [TW-1:0]           pop_cnt;
  logic [AW-1:0]           tap;
  logic [WEIGHT_WIDTH-1:0] w [KERNEL_LEN];
  logic                    start_job;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   head;

  assign start_job = (state == ST_IDLE) && start;
  assign pix_ready = (state == ST_RUN) && !fifo_full && (push_cnt < total);
  assign push      = pix_valid && pix_ready;
  assign pop       = (state == ST_RUN) && !fifo_empty;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  pe_feeder_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (pix_data),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = (num_windows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (pop_cnt == total) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Weights are only writable between jobs so a running window never sees a torn kernel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < KERNEL_LEN; i++) w[i] <= '0;
    end else if (cfg_wr_en && (state == ST_IDLE) && ({1'b0, cfg_wr_addr} < KLEN_A)) begin
      w[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      total     <= '0;
      push_cnt  <= '0;
      pop_cnt   <= '0;
      tap       <= '0;
      pe_en     <= 1'b0;
      pe_input  <= '0;
      pe_weight <= '0;
      win_last  <= 1'b0;
    end else begin
      if (start_job) begin
        total    <= TW'(num_windows) * KLEN_T;
        push_cnt <= '0;
        pop_cnt  <= '0;
        tap      <= '0;
      end
      if (push) push_cnt <= push_cnt + 1'b1;
      // Tap only advances on a real pop, so source bubbles never skip a tap.
      if (pop) begin
        pop_cnt <= pop_cnt + 1'b1;
        tap     <= (tap == TAP_LAST) ? '0 : tap + 1'b1;
      end
      pe_en     <= pop;
      pe_input  <= pop ? head : '0;
      pe_weight <= pop ? w[tap] : '0;
      win_last  <= pop && (tap == TAP_LAST);
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: job table, randomized jobs and reset/config corner cases.
module tb_pe_feeder;

  localparam int K = 9;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [7:0]  cfg_wr_data = '0;
  logic [15:0] num_windows = '0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic [7:0]  pe_input;
  logic [7:0]  pe_weight;
  logic        pe_en;
  logic        win_last;
  logic        busy;
  logic        done;

  pe_feeder #(
    .DATA_WIDTH   (8),
    .WEIGHT_WIDTH (8),
    .KERNEL_LEN   (K),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .num_windows (num_windows),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .pe_input    (pe_input),
    .pe_weight   (pe_weight),
    .pe_en       (pe_en),
    .win_last    (win_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_seen;
  int idle_bad;
  logic acc;
  logic [7:0] obs_pix[$];
  logic [7:0] obs_w[$];
  logic       obs_last[$];
  int         obs_step[$];
  int         done_steps[$];
  logic [7:0] wm[K];

  typedef struct {
    int nw;
    int pct;
    int extra;
    int seq;
    int exp_acc;
  } job_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshake before the edge, outputs at the following negedge.
  task automatic step();
    #1;
    acc = pix_valid && pix_ready;
    if (pix_ready) ready_seen++;
    @(negedge clk);
    cyc++;
    if (pe_en) begin
      obs_pix.push_back(pe_input);
      obs_w.push_back(pe_weight);
      obs_last.push_back(win_last);
      obs_step.push_back(cyc);
    end else if (pe_input != 0 || pe_weight != 0 || win_last != 0) begin
      idle_bad++;
    end
    if (done) done_steps.push_back(cyc);
  endtask

  task automatic clear_obs();
    obs_pix.delete();
    obs_w.delete();
    obs_last.delete();
    obs_step.delete();
    done_steps.delete();
    ready_seen = 0;
    idle_bad   = 0;
  endtask

  task automatic write_w(input int addr, input logic [7:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 4'(addr);
    cfg_wr_data = data;
    step();
    cfg_wr_en = 1'b0;
    if (addr < K) wm[addr] = data;
  endtask

  task automatic run_job(input int nw, input int pct, input int extra, input int seq,
                         input int busy_wr, input int exp_acc);
    logic [7:0] src[$];
    int total = nw * K;
    int idx = 0;
    int first_acc = -1;
    int start_step;
    int budget = 3000;
    for (int i = 0; i < total + extra; i++) src.push_back(seq != 0 ? 8'(10 + i) : 8'($urandom));
    clear_obs();
    num_windows = 16'(nw);
    start = 1'b1;
    step();
    start = 1'b0;
    start_step = cyc;
    check("busy_after_start", busy, 1);
    while (done_steps.size() == 0 && budget > 0) begin
      cfg_wr_en   = (busy_wr != 0) && (cyc == start_step);
      cfg_wr_addr = '0;
      cfg_wr_data = 8'h55;
      pix_valid = (idx < src.size()) && ($urandom_range(99) < pct);
      pix_data  = (idx < src.size()) ? src[idx] : 8'h00;
      step();
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      budget--;
    end
    cfg_wr_en = 1'b0;
    pix_valid = 1'b0;
    check("done_within_budget", done_steps.size() != 0, 1);
    step();
    check("busy_low_after_done", busy, 0);
    step();
    check("done_pulse_count", done_steps.size(), 1);
    check("pixels_accepted", idx, exp_acc);
    check("pe_en_count", obs_pix.size(), exp_acc);
    check("idle_operands_zero", idle_bad, 0);
    for (int i = 0; i < obs_pix.size() && i < total; i++) begin
      check("pe_input", obs_pix[i], src[i]);
      check("pe_weight", obs_w[i], wm[i % K]);
      check("win_last", obs_last[i], (i % K) == K - 1);
    end
    if (done_steps.size() != 0) begin
      if (total == 0) begin
        check("done_after_empty_start", done_steps[0], start_step);
        check("ready_never_high", ready_seen, 0);
      end else if (obs_step.size() != 0) begin
        check("done_after_last_pe_en", done_steps[0], obs_step[obs_step.size() - 1] + 1);
      end
    end
    if (total != 0 && obs_step.size() != 0 && first_acc >= 0)
      check("first_pixel_latency", obs_step[0], first_acc + 1);
  endtask

  job_t jobs[6];

  initial begin
    jobs[0] = '{nw: 1, pct: 100, extra: 0, seq: 1, exp_acc: 9};
    jobs[1] = '{nw: 2, pct: 50,  extra: 0, seq: 0, exp_acc: 18};
    jobs[2] = '{nw: 2, pct: 100, extra: 2, seq: 0, exp_acc: 18};
    jobs[3] = '{nw: 0, pct: 100, extra: 5, seq: 0, exp_acc: 0};
    jobs[4] = '{nw: 3, pct: 30,  extra: 4, seq: 0, exp_acc: 27};
    jobs[5] = '{nw: 1, pct: 100, extra: 3, seq: 0, exp_acc: 9};
    for (int i = 0; i < K; i++) wm[i] = '0;
    clear_obs();

    @(negedge clk);
    rstn = 1'b0;
    step();
    step();
    check("rst_pe_en", pe_en, 0);
    check("rst_pe_input", pe_input, 0);
    check("rst_pe_weight", pe_weight, 0);
    check("rst_win_last", win_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_ready", pix_ready, 0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < K; i++) write_w(i, 8'(i + 1));
    for (int j = 0; j < 6; j++) begin
      if (j > 0) for (int i = 0; i < K; i++) write_w(i, 8'($urandom));
      run_job(jobs[j].nw, jobs[j].pct, jobs[j].extra, jobs[j].seq, 0, jobs[j].exp_acc);
    end

    for (int r = 0; r < 6; r++) begin
      int nw = $urandom_range(0, 3);
      for (int i = 0; i < K; i++) write_w(i, 8'($urandom));
      run_job(nw, $urandom_range(20, 100), $urandom_range(0, 5), 0, 0, nw * K);
    end

    // Config writes while busy are dropped; in IDLE they land; out-of-range addresses are dropped.
    for (int i = 0; i < K; i++) write_w(i, 8'(i + 1));
    run_job(1, 100, 0, 0, 1, 9);
    write_w(0, 8'h55);
    run_job(1, 100, 0, 0, 0, 9);
    for (int a = K; a < 16; a++) write_w(a, 8'hEE);
    run_job(1, 70, 0, 0, 0, 9);

    // Reset in the middle of a job.
    for (int i = 0; i < K; i++) write_w(i, 8'($urandom_range(1, 255)));
    clear_obs();
    num_windows = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 100 && obs_pix.size() < 5; b++) begin
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      step();
    end
    check("pops_before_reset", obs_pix.size(), 5);
    pix_valid = 1'b0;
    rstn = 1'b0;
    step();
    check("midrst_pe_en", pe_en, 0);
    check("midrst_pe_input", pe_input, 0);
    check("midrst_pe_weight", pe_weight, 0);
    check("midrst_win_last", win_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    rstn = 1'b1;
    done_steps.delete();
    repeat (4) step();
    check("no_done_after_reset", done_steps.size(), 0);
    for (int i = 0; i < K; i++) wm[i] = '0;
    run_job(1, 100, 0, 0, 0, 9);
    for (int i = 0; i < K; i++) write_w(i, 8'(20 + i));
    run_job(2, 60, 1, 0, 0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
